// File: rtl/ahb_lite_master_ctrl.sv
// AHB-Lite master controller: runs one word-wide INCR/SINGLE burst per command,
// moving data between the local register file and the AHB bus.
module ahb_lite_master_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BEATS  = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  cmd_start,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [3:0]            cmd_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_BURST,
    S_LAST,
    S_ERR
  } state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;
  localparam logic [2:0] BR_SINGLE = 3'b000;
  localparam logic [2:0] BR_INCR   = 3'b001;
  localparam logic [3:0] MAX_LEN   = 4'(MAX_BEATS);

  state_t          state;
  logic [3:0]      beats_left;
  logic            dph_vld_p1;
  logic [3:0]      len_eff;
  logic [ADDR_WIDTH-1:0] addr_next;

  // Zero-length commands run one beat; anything above the register-file depth saturates.
  function automatic logic [3:0] clamp_len(input logic [3:0] len);
    if (len == 4'd0)
      return 4'd1;
    else if (len > MAX_LEN)
      return MAX_LEN;
    else
      return len;
  endfunction

  // A SEQ beat may not cross a 1KB page, so the first beat of a new page restarts as NONSEQ.
  function automatic logic [1:0] seq_trans(input logic [ADDR_WIDTH-1:0] addr);
    if (addr[9:0] == 10'd0)
      return TR_NONSEQ;
    else
      return TR_SEQ;
  endfunction

  assign len_eff   = clamp_len(cmd_len);
  assign addr_next = HADDR + ADDR_WIDTH'(4);

  assign HSIZE    = 3'b010;
  assign HWDATA   = mem_rdata;
  assign mem_read = HTRANS[1] & HWRITE & HREADY;

  // Data-phase tracking and read-data capture into the register file.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dph_vld_p1 <= 1'b0;
      mem_write  <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      if (HREADY)
        dph_vld_p1 <= HTRANS[1];
      mem_write <= 1'b0;
      if (dph_vld_p1 && !HWRITE && HREADY && !HRESP) begin
        mem_wdata <= HRDATA;
        mem_write <= 1'b1;
      end
    end
  end

  // Burst FSM driving the registered AHB address-phase outputs and status.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state      <= S_IDLE;
      beats_left <= '0;
      HADDR      <= '0;
      HTRANS     <= TR_IDLE;
      HWRITE     <= 1'b0;
      HBURST     <= BR_SINGLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (dph_vld_p1 && !HREADY && HRESP && (state != S_ERR)) begin
        state  <= S_ERR;
        HTRANS <= TR_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (cmd_start && !done) begin
              state      <= S_ADDR;
              busy       <= 1'b1;
              HADDR      <= {cmd_addr[ADDR_WIDTH-1:2], 2'b00};
              HTRANS     <= TR_NONSEQ;
              HWRITE     <= cmd_write;
              HBURST     <= (len_eff == 4'd1) ? BR_SINGLE : BR_INCR;
              beats_left <= len_eff - 4'd1;
            end
          end
          S_ADDR, S_BURST: begin
            if (HREADY) begin
              if (beats_left == 4'd0) begin
                state  <= S_LAST;
                HTRANS <= TR_IDLE;
              end else begin
                state      <= S_BURST;
                HADDR      <= addr_next;
                HTRANS     <= seq_trans(addr_next);
                beats_left <= beats_left - 4'd1;
              end
            end
          end
          S_LAST: begin
            if (HREADY) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
          S_ERR: begin
            if (HREADY) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
              err   <= 1'b1;
            end
          end
          default: begin
            state  <= S_IDLE;
            HTRANS <= TR_IDLE;
            busy   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
